// File: rtl/mem_pkg.sv
// mem_pkg: shared length encodings, FSM states and alignment check for the data-memory responder
package mem_pkg;
  typedef enum logic [1:0] {
    MEM_BYTE = 2'b00,
    MEM_HALF = 2'b01,
    MEM_WORD = 2'b10,
    MEM_RSVD = 2'b11
  } mem_len_t;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  function automatic logic mem_misaligned(mem_len_t len, logic [1:0] addr);
    return (len == MEM_HALF && addr[0]) || (len == MEM_WORD && addr != 2'b00);
  endfunction
endpackage

// File: rtl/dmem_responder_if.sv
// dmem_responder_if: request/response handshake bundle between the memory stage and the responder
interface dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [1:0]  req_length;
  logic        req_sign;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        busy;

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_length, req_sign, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err, busy
  );

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_length, req_sign, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err, busy
  );
endinterface

// File: rtl/mem_lane_align.sv
// mem_lane_align: little-endian byte-lane steering for stores and extraction/extension for loads
module mem_lane_align
  import mem_pkg::*;
(
  input  mem_len_t    len,
  input  logic        sign,
  input  logic [1:0]  addr,
  input  logic [31:0] wdata,
  input  logic [31:0] raw,
  output logic [3:0]  be,
  output logic [31:0] wlane,
  output logic [31:0] rdata
);
  logic [15:0] sh;
  // replicate store data over every lane so the byte enables alone pick the target lanes
  always_comb begin
    be    = len == MEM_WORD ? 4'b1111 : len == MEM_HALF ? (addr[1] ? 4'b1100 : 4'b0011) : 4'b0001 << addr;
    wlane = len == MEM_WORD ? wdata : len == MEM_HALF ? {2{wdata[15:0]}} : {4{wdata[7:0]}};
    sh    = 16'(raw >> {addr, 3'b000});
    rdata = len == MEM_WORD ? raw :
            len == MEM_HALF ? {{16{sign & sh[15]}}, sh[15:0]} : {{24{sign & sh[7]}}, sh[7:0]};
  end
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: one-at-a-time load/store responder with programmable access latency
module dmem_responder
  import mem_pkg::*;
#(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input logic clk,
  input logic rst,
  dmem_responder_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(LATENCY + 1);

  state_t      state;
  logic [CW-1:0] cnt;
  logic        c_write, c_sign;
  logic [31:0] c_addr, c_wdata;
  mem_len_t    c_len;
  logic [31:0] mem [DEPTH];
  logic        a_write, a_sign, err, enter;
  logic [31:0] a_addr, a_wdata, rdata, wlane;
  mem_len_t    a_len;
  logic [3:0]  be;
  logic [AW-1:0] idx;

  // in IDLE the live request is used so a single-cycle latency can access on the accepting edge
  always_comb begin
    a_write = state == IDLE ? bus.req_write : c_write;
    a_sign  = state == IDLE ? bus.req_sign : c_sign;
    a_addr  = state == IDLE ? bus.req_addr : c_addr;
    a_wdata = state == IDLE ? bus.req_wdata : c_wdata;
    a_len   = state == IDLE ? mem_len_t'(bus.req_length) : c_len;
    idx     = a_addr[AW+1:2];
    err     = a_len == MEM_RSVD || mem_misaligned(a_len, a_addr[1:0]) || |a_addr[31:AW+2];
    enter   = (state == IDLE && bus.req_valid && LATENCY == 1) || (state == WAIT && cnt == '0);
  end

  mem_lane_align u_align (
    .len(a_len), .sign(a_sign), .addr(a_addr[1:0]), .wdata(a_wdata),
    .raw(mem[idx]), .be(be), .wlane(wlane), .rdata(rdata)
  );

  // array write on the edge entering RESP; a reset on that edge cancels it
  always_ff @(posedge clk)
    if (!rst && enter && a_write && !err)
      for (int i = 0; i < 4; i++)
        if (be[i]) mem[idx][8*i +: 8] <= wlane[8*i +: 8];

  // FSM, latency counter, request capture and held response
  always_ff @(posedge clk)
    if (rst) begin
      state          <= IDLE;
      cnt            <= '0;
      bus.resp_valid <= 1'b0;
      bus.resp_rdata <= '0;
      bus.resp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.req_valid) begin
          c_write <= bus.req_write;
          c_sign  <= bus.req_sign;
          c_addr  <= bus.req_addr;
          c_wdata <= bus.req_wdata;
          c_len   <= mem_len_t'(bus.req_length);
          state   <= WAIT;
          cnt     <= CW'(LATENCY - 2);
        end
        WAIT: if (cnt != '0) cnt <= cnt - CW'(1);
        RESP: if (bus.resp_ready) begin
          state          <= IDLE;
          bus.resp_valid <= 1'b0;
        end
        default: state <= IDLE;
      endcase
      if (enter) begin
        state          <= RESP;
        bus.resp_valid <= 1'b1;
        bus.resp_err   <= err;
        bus.resp_rdata <= (a_write || err) ? '0 : rdata;
      end
    end

  assign bus.req_ready = state == IDLE;
  assign bus.busy      = state != IDLE;
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: scoreboard bench with a byte-array reference model
module tb_dmem_responder;
  localparam int DEPTH   = 1024;
  localparam int LATENCY = 2;

  typedef struct packed {logic err; logic [31:0] data;} exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic hold = 1'b0;
  logic pv = 1'b0;
  int total = 0, bad = 0, cyc = 0, acc = 0;
  logic [7:0] refm [DEPTH*4];
  exp_t q[$];

  dmem_responder_if bus();
  dmem_responder #(.DEPTH(DEPTH), .LATENCY(LATENCY)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) begin
    #1;
    bus.resp_ready = hold ? 1'b0 : ($urandom_range(3) != 0);
  end

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s actual=%h required=%h t=%0t", n, a, e, $time);
    end
  endtask

  function automatic exp_t model(input logic w, input logic [31:0] a, input logic [31:0] d,
                                 input logic [1:0] len, input logic s);
    exp_t r;
    int n;
    logic [31:0] v;
    r.err = len == 2'b11 || (len == 2'b01 && a[0]) || (len == 2'b10 && a[1:0] != 2'b00) ||
            a >= 32'(DEPTH * 4);
    r.data = '0;
    if (r.err) return r;
    n = 1 << len;
    if (w) begin
      for (int i = 0; i < n; i++) refm[a+i] = d[8*i +: 8];
    end else begin
      v = '0;
      for (int i = 0; i < n; i++) v[8*i +: 8] = refm[a+i];
      if (s && n < 4 && v[8*n-1])
        for (int i = 8 * n; i < 32; i++) v[i] = 1'b1;
      r.data = v;
    end
    return r;
  endfunction

  task automatic req(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [1:0] len,
                     input logic s, input bit drop = 0, input bit use_exp = 0,
                     input logic e_err = 0, input logic [31:0] e_data = 0);
    int t;
    exp_t m;
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_write  = w;
    bus.req_addr   = a;
    bus.req_wdata  = d;
    bus.req_length = len;
    bus.req_sign   = s;
    t = 0;
    while (!bus.req_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!bus.req_ready) begin
      chk("accept_timeout", 32'd1, 32'd0);
      bus.req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    acc = cyc;
    bus.req_valid = 1'b0;
    if (!drop) begin
      m = model(w, a, d, len, s);
      if (use_exp) begin
        m.err  = e_err;
        m.data = e_data;
      end
      q.push_back(m);
    end
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while ((q.size() != 0 || bus.busy) && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (q.size() != 0 || bus.busy) chk("drain_timeout", 32'd1, 32'd0);
  endtask

  always @(negedge clk) begin
    if (!rst && bus.resp_valid) begin
      if (!pv) chk("latency", 32'(cyc - acc), 32'(LATENCY - 1));
      chk("busy_in_resp", 32'(bus.busy), 32'd1);
      chk("ready_in_resp", 32'(bus.req_ready), 32'd0);
      if (q.size() == 0) chk("unexpected_resp", 32'd1, 32'd0);
      else begin
        chk("resp_err", 32'(bus.resp_err), 32'(q[0].err));
        chk("resp_rdata", bus.resp_rdata, q[0].data);
        if (bus.resp_ready) void'(q.pop_front());
      end
    end
    pv = bus.resp_valid;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int t;
    logic [31:0] a;
    logic [1:0] len;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr = '0;
    bus.req_wdata = '0;
    bus.req_length = 2'b00;
    bus.req_sign = 1'b0;
    bus.resp_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("rst_resp_rdata", bus.resp_rdata, 32'd0);
    chk("rst_resp_err", 32'(bus.resp_err), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    rst = 1'b0;
    chk("rst_req_ready", 32'(bus.req_ready), 32'd1);

    for (int i = 0; i < 16; i++) req(1'b1, 32'(i * 4), 32'd0, 2'b10, 1'b0);
    wait_idle();

    req(1'b1, 32'h10, 32'hDEADBEEF, 2'b10, 1'b0, 0, 1, 1'b0, 32'h0);
    req(1'b0, 32'h10, 32'h0, 2'b10, 1'b0, 0, 1, 1'b0, 32'hDEADBEEF);
    req(1'b0, 32'h11, 32'h0, 2'b00, 1'b1, 0, 1, 1'b0, 32'hFFFFFFBE);
    req(1'b0, 32'h11, 32'h0, 2'b00, 1'b0, 0, 1, 1'b0, 32'h000000BE);
    req(1'b0, 32'h12, 32'h0, 2'b01, 1'b1, 0, 1, 1'b0, 32'hFFFFDEAD);
    req(1'b0, 32'h12, 32'h0, 2'b01, 1'b0, 0, 1, 1'b0, 32'h0000DEAD);
    req(1'b1, 32'h13, 32'h55, 2'b00, 1'b0, 0, 1, 1'b0, 32'h0);
    req(1'b0, 32'h10, 32'h0, 2'b10, 1'b0, 0, 1, 1'b0, 32'h55ADBEEF);

    req(1'b1, 32'h11, 32'hFFFF, 2'b01, 1'b0, 0, 1, 1'b1, 32'h0);
    req(1'b0, 32'h10, 32'h0, 2'b10, 1'b0, 0, 1, 1'b0, 32'h55ADBEEF);
    req(1'b0, 32'h12, 32'h0, 2'b10, 1'b0, 0, 1, 1'b1, 32'h0);
    req(1'b0, 32'h10, 32'h0, 2'b10, 1'b0, 0, 1, 1'b0, 32'h55ADBEEF);
    req(1'b1, 32'h10, 32'hFFFFFFFF, 2'b11, 1'b0, 0, 1, 1'b1, 32'h0);
    req(1'b0, 32'h10, 32'h0, 2'b10, 1'b0, 0, 1, 1'b0, 32'h55ADBEEF);
    req(1'b1, 32'h1000, 32'hFFFFFFFF, 2'b10, 1'b0, 0, 1, 1'b1, 32'h0);
    req(1'b0, 32'h0, 32'h0, 2'b10, 1'b0, 0, 1, 1'b0, 32'h0);
    wait_idle();

    hold = 1'b1;
    req(1'b0, 32'h10, 32'h0, 2'b10, 1'b0, 0, 1, 1'b0, 32'h55ADBEEF);
    t = 0;
    while (!bus.resp_valid && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("bp_resp_valid", 32'(bus.resp_valid), 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus.req_valid = 1'b1;
      bus.req_write = 1'b1;
      bus.req_addr = 32'h10;
      bus.req_wdata = 32'h0;
      bus.req_length = 2'b10;
      chk("bp_valid_held", 32'(bus.resp_valid), 32'd1);
      chk("bp_req_ready", 32'(bus.req_ready), 32'd0);
    end
    bus.req_valid = 1'b0;
    hold = 1'b0;
    wait_idle();
    req(1'b0, 32'h10, 32'h0, 2'b10, 1'b0, 0, 1, 1'b0, 32'h55ADBEEF);
    wait_idle();

    req(1'b1, 32'h20, 32'h12345678, 2'b10, 1'b0, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_wait_busy", 32'(bus.busy), 32'd0);
    chk("rst_wait_resp_valid", 32'(bus.resp_valid), 32'd0);
    req(1'b0, 32'h20, 32'h0, 2'b10, 1'b0, 0, 1, 1'b0, 32'h0);
    wait_idle();

    for (int i = 0; i < 300; i++) begin
      a = $urandom_range(9) == 0 ? 32'h1000 + ($urandom & 32'h0FFF_FFFF) : 32'($urandom_range(63));
      len = $urandom_range(9) == 0 ? 2'b11 : 2'($urandom_range(2));
      req(1'($urandom_range(1)), a, $urandom, len, 1'($urandom_range(1)));
    end
    wait_idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder serving the load/store requests issued by the processor memory stage.
- Accepts one request at a time via a valid/ready handshake, waits a programmable access latency, then performs the access.
- Load/store width (byte/half/word) and load sign-extension are applied inside the block, little-endian.
- Returns a held response with read data and error flag; `busy` drives the pipeline stall logic.

Parameters:
- DEPTH, 1024, number of 32-bit words in the array (power of two, >=4).
- LATENCY, 2, cycles from request acceptance to resp_valid (>=1).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept.
- req_write  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned.
- req_length  in  2  00 byte, 01 half, 10 word, 11 reserved.
- req_sign  in  1  load: 1 sign-extend, 0 zero-extend.
- resp_valid  out  1  response present.
- resp_ready  in  1  requester consumes response.
- resp_rdata  out  32  load result, extended; 0 for stores and errors.
- resp_err  out  1  misaligned / reserved length / out of range.
- busy  out  1  state != IDLE.

Behaviour:
- Reset: one clock, synchronous, active-high. Takes effect on the next clk edge.
  - State returns to IDLE; resp_valid=0, resp_rdata=0, resp_err=0, busy=0; latency counter=0.
  - Array contents are not cleared.
- FSM states:
  - IDLE: req_ready=1. On req_valid & req_ready, capture all req_* fields. If LATENCY==1 go to RESP; otherwise go to WAIT with cnt=LATENCY-2.
  - WAIT: req_ready=0. If cnt==0 go to RESP; else cnt-1.
  - RESP: req_ready=0, resp_valid=1. resp_rdata/resp_err stay stable until resp_ready=1, then go to IDLE.
- Timing:
  - Acceptance at edge T gives resp_valid high from the cycle after edge T+LATENCY-1.
  - For LATENCY=1, resp_valid is high in the cycle immediately after acceptance.
  - Throughput is at most one request per LATENCY+1 cycles; no request is accepted in the RESP cycle.
- Access point: the array is read or written on the edge entering RESP. Read data is registered, formatted, then held.
- Error checks, made on the captured fields:
  - length==11.
  - half with addr[0]=1.
  - word with addr[1:0]!=0.
  - addr[31:2] >= DEPTH.
  - On any error: no array write, resp_err=1, resp_rdata=0.
- Stores:
  - byte: wdata[7:0] to lane addr[1:0].
  - half: wdata[15:0] to lanes {addr[1],0} and {addr[1],1}.
  - word: all four lanes.
  - Unselected lanes are unchanged. resp_rdata=0.
- Loads:
  - Extract the selected lane(s).
  - Bit 7 (byte) or bit 15 (half) is replicated when req_sign=1; otherwise the upper bits are zero.
  - Word loads ignore req_sign.
- Request inputs are ignored outside IDLE; the captured copy is authoritative.
- Reset mid-operation:
  - In WAIT: the request is dropped with no write.
  - In RESP: the response is dropped; a write already performed persists.
- resp_ready while not in RESP is ignored.

Decomposition:
- Shared package mem_pkg:
  - MEM_BYTE/MEM_HALF/MEM_WORD length encodings, plus a reserved encoding.
  - Typedef mem_len_t (2 bits).
  - Function mem_misaligned(len, addr).
- Sub-module mem_lane_align, combinational:
  - Store path: byte-enable mask and shifted write data from (len, addr[1:0], wdata).
  - Load path: extracted/extended data from (len, sign, addr[1:0], raw word).
- Top holds the FSM, counter, capture registers and array.

Test Plan (LATENCY=2, DEPTH=1024):
1. Word store then load. Store word 0xDEADBEEF @0x10; complete handshake; load word @0x10.
   -> resp_valid exactly 2 cycles after each accept; load returns 0xDEADBEEF, resp_err=0.
2. Byte and half loads with extension. After test 1:
   -> load byte signed @0x11 returns 0xFFFFFFBE.
   -> load byte unsigned @0x11 returns 0x000000BE.
   -> load half signed @0x12 returns 0xFFFFDEAD.
   -> load half unsigned @0x12 returns 0x0000DEAD.
3. Partial store. Store byte 0x55 @0x13, then load word @0x10.
   -> returns 0x55ADBEEF; other lanes intact.
4. Errors, each followed by a word load @0x10 confirming no write:
   -> half store @0x11: resp_err=1, rdata=0.
   -> word load @0x12: resp_err=1, rdata=0.
   -> length 11: resp_err=1, rdata=0.
   -> addr 0x1000 (index 1024): resp_err=1, rdata=0.
5. Backpressure. Hold resp_ready=0 for 5 cycles in RESP.
   -> resp_valid, resp_rdata and resp_err stable; req_ready=0; busy=1; a new req_valid is not accepted.
6. Reset in WAIT. Accept store word 0x12345678 @0x20, assert rst the next cycle, then load @0x20.
   -> busy=0 and resp_valid=0 after reset; load returns the previous contents (0x00000000 if written to 0 earlier).
